// File: rtl/pc_sequencer.sv
// pc_sequencer: two-state (FETCH/EXEC) program-counter sequencer.
// Issues one instruction fetch at pc, waits for the execute stage to finish,
// then loads the branch unit's next PC and counts the retirement.
// Optional feature: define PC_MISALIGN_TRAP_EN to redirect misaligned targets
// to TRAP_VEC (with a misalign_trap pulse and no retirement count).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic [31:0] new_pc,
    input  logic [31:0] pc_plus4,
    output logic [31:0] pc,
    output logic        redirect,
    output logic [31:0] instret,
    output logic        misalign_trap
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        fetch_fire;
    logic        retire;
    logic        trap_hit;
    logic [31:0] pc_next;
    logic [31:0] instret_count;

    // Retirement counter step; wraps silently at the top of the 32-bit range.
    function automatic logic [31:0] count_step(input logic [31:0] count);
        return count + 32'd1;
    endfunction

`ifdef PC_MISALIGN_TRAP_EN
    // A branch target is misaligned when either of its low two bits is set.
    function automatic logic is_misaligned(input logic [31:0] target);
        return target[1:0] != 2'b00;
    endfunction

    assign trap_hit = retire && is_misaligned(new_pc);
`else
    assign trap_hit = 1'b0;
`endif

    // A fetch is only requested from FETCH and never while stalled.
    assign imem_req   = (state == FETCH) && !stall;
    assign fetch_fire = imem_req && imem_ack;
    // Stall does not hold back completion of an instruction already in EXEC.
    assign retire     = (state == EXEC) && exec_done;
    assign pc_next    = trap_hit ? TRAP_VEC : new_pc;
    assign imem_addr  = pc;
    assign instret    = instret_count;

    // Next-state logic: FETCH waits for an accepted fetch, EXEC waits for exec_done.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (fetch_fire) state_next = EXEC;
            EXEC:    if (retire)     state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // PC, retirement counter and the one-cycle status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= RESET_PC;
            instret_count <= 32'd0;
            instr_valid   <= 1'b0;
            redirect      <= 1'b0;
        end else begin
            instr_valid <= fetch_fire;
            redirect    <= retire && (trap_hit || (new_pc != pc_plus4));
            if (retire) begin
                pc <= pc_next;
            end
            if (retire && !trap_hit) begin
                instret_count <= count_step(instret_count);
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Misaligned-target pulse, registered alongside the PC update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= trap_hit;
        end
    end
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, misaligned-target redirect address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, hold sequencing: fetch not issued while high.
REQ-006 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-007 SHALL have port imem_addr, output, 32, fetch address, always equal to pc.
REQ-008 SHALL have port imem_ack, input, 1, fetch completion from instruction memory.
REQ-009 SHALL have port instr_valid, output, 1, one-cycle pulse: fetched instruction ready for decode/execute.
REQ-010 SHALL have port exec_done, input, 1, execute stage finished; new_pc and pc_plus4 valid.
REQ-011 SHALL have port new_pc, input, 32, next PC from the branch unit.
REQ-012 SHALL have port pc_plus4, input, 32, sequential PC from the branch unit.
REQ-013 SHALL have port pc, output, 32, current program counter fed to the branch unit.
REQ-014 SHALL have port redirect, output, 1, one-cycle pulse when the PC update is non-sequential.
REQ-015 SHALL have port instret, output, 32, retired-instruction counter.
REQ-016 SHALL have port misalign_trap, output, 1, one-cycle pulse on misaligned target (only with PC_MISALIGN_TRAP_EN).

Function
REQ-017 SHALL implement FSM with states FETCH and EXEC.
REQ-018 SHALL drive imem_req = (state==FETCH) && !stall, combinationally.
REQ-019 In FETCH, imem_req && imem_ack SHALL move to EXEC and register instr_valid=1 for exactly the next cycle.
REQ-020 imem_ack with imem_req low (stall high, or state EXEC) SHALL be ignored.
REQ-021 In EXEC, exec_done SHALL load pc<=new_pc, increment instret and return to FETCH on the same edge.
REQ-022 exec_done in FETCH SHALL be ignored; stall SHALL NOT block exec_done in EXEC.
REQ-023 On each PC update, redirect SHALL be registered high for one cycle iff new_pc != pc_plus4.
REQ-024 Minimum throughput SHALL be 2 cycles per instruction: ack in first FETCH cycle, exec_done in first EXEC cycle.
REQ-025 instret SHALL wrap 32'hFFFF_FFFF -> 0 with no flag; pc SHALL take new_pc unmodified, including wrap.
REQ-026 pc and imem_addr SHALL remain stable while in FETCH and EXEC until a PC update.

Reset
REQ-027 reset_n low SHALL immediately force state=FETCH, pc=RESET_PC, instret=0, instr_valid=0, redirect=0, misalign_trap=0.
REQ-028 Reset asserted mid-fetch or mid-execute SHALL abandon the instruction with no retirement; first fetch after release SHALL be at RESET_PC.

Configuration
REQ-029 With macro PC_MISALIGN_TRAP_EN defined, exec_done with new_pc[1:0]!=2'b00 SHALL load pc<=TRAP_VEC, pulse misalign_trap and redirect, and SHALL NOT increment instret.
REQ-030 Without PC_MISALIGN_TRAP_EN, misalign_trap SHALL be tied 0 and new_pc SHALL be loaded unchecked.

Verification
REQ-031 Reset release, stall=0, imem_ack=1 immediately -> imem_req=1 with imem_addr=0 in cycle 0; instr_valid=1 in cycle 1.
REQ-032 pc=0x10, exec_done with new_pc=0x14, pc_plus4=0x14 -> pc=0x14, redirect=0, instret+1.
REQ-033 pc=0x10, exec_done with new_pc=0x40, pc_plus4=0x14 -> pc=0x40, redirect pulse 1 cycle, next imem_addr=0x40.
REQ-034 stall=1 for 3 cycles in FETCH with imem_ack=1 -> imem_req=0, no instr_valid; fetch completes the cycle stall drops.
REQ-035 instret preset to 0xFFFF_FFFF by retirements/force, one exec_done -> instret=0; reset_n pulse mid-EXEC -> pc=RESET_PC, instret=0.
REQ-036 With PC_MISALIGN_TRAP_EN, exec_done with new_pc=0x42 -> pc=0x100, misalign_trap and redirect pulse, instret unchanged.
